load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit that splits byte, halfword and word accesses into single-byte
// memory cycles, assembling load data and slicing store data by configured endianness.
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      r_state;
  logic        r_write;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;     // nbytes - 1
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_asm;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;

  logic [1:0]  w_req_last;
  logic        w_req_err;
  logic [31:0] w_asm_next;
  logic [31:0] w_ext;

  // Bit lane (in bytes) that access byte k occupies within the right-aligned value.
  function automatic logic [1:0] lane(input logic [1:0] last, input logic [1:0] k);
    return BIG_ENDIAN ? (last - k) : k;
  endfunction

  function automatic logic [7:0] sel_byte(input logic [31:0] d, input logic [1:0] last,
                                          input logic [1:0] k);
    return d[{lane(last, k), 3'b000} +: 8];
  endfunction

  always_comb begin
    case (req_size)
      2'b00:   w_req_last = 2'd0;
      2'b01:   w_req_last = 2'd1;
      default: w_req_last = 2'd3;
    endcase
    w_req_err = (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    w_asm_next = r_asm;
    w_asm_next[{lane(r_last, r_cnt), 3'b000} +: 8] = mem_rdata;
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_asm_next[7]}}, w_asm_next[7:0]};
      2'b01:   w_ext = {{16{r_signed & w_asm_next[15]}}, w_asm_next[15:0]};
      default: w_ext = w_asm_next;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= 2'b00;
      r_cnt        <= 2'd0;
      r_last       <= 2'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_asm        <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 8'd0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= 2'd0;
            r_last   <= w_req_last;
            r_asm    <= 32'd0;
            if (w_req_err) begin
              r_state      <= DONE;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state     <= ACCESS;
              r_mem_addr  <= req_addr;
              r_mem_read  <= ~req_write;
              r_mem_write <= req_write;
              r_mem_wdata <= req_write ? sel_byte(req_wdata, w_req_last, 2'd0) : 8'd0;
            end
          end
        end
        ACCESS: begin
          r_asm <= w_asm_next;
          if (r_cnt == r_last) begin
            r_state      <= DONE;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 8'd0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_write ? 32'd0 : w_ext;
          end else begin
            r_cnt       <= r_cnt + 2'd1;
            r_mem_addr  <= r_addr + {30'd0, r_cnt + 2'd1};
            r_mem_wdata <= r_write ? sel_byte(r_wdata, r_last, r_cnt + 2'd1) : 8'd0;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (big-endian) against a 64-byte memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [64];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [7:0]  pre_data;
  int          strobe_cnt;
  int          n_checks;
  int          n_fail;

  load_store_unit #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide memory; addresses alias modulo 64 (0xFFFFFFFF maps to 0x3F).
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  initial strobe_cnt = 0;
  always @(posedge clk) if (mem_read || mem_write) strobe_cnt <= strobe_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st_bytes [4];
    st_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    pre_we = 1'b0; pre_addr = 6'd0; pre_data = 8'd0;
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);

    preload(6'h20, 8'h80);
    preload(6'h21, 8'h01);
    preload(6'h3F, 8'h7F);
    reset = 1'b0;

    // Word store, big-endian byte order
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4);
    chk("st_ready_low", req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk($sformatf("st_addr%0d", k), mem_addr, 32'h10 + k);
      chk($sformatf("st_wdata%0d", k), mem_wdata, st_bytes[k]);
      chk($sformatf("st_strobe%0d", k), {mem_read, mem_write}, 2'b01);
      chk($sformatf("st_noresp%0d", k), resp_valid, 0);
    end
    tick();
    chk("st_resp_valid", resp_valid, 1);
    chk("st_resp_err", resp_err, 0);
    chk("st_resp_rdata", resp_rdata, 0);
    chk("st_idle_mem", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
    tick();
    chk("st_resp_drop", resp_valid, 0);
    chk("st_ready_back", req_ready, 1);
    for (int k = 0; k < 4; k++) chk($sformatf("st_mem%0d", k), mem[6'h10 + k], st_bytes[k]);

    // Signed and unsigned halfword loads
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    chk("lh_addr0", mem_addr, 32'h20);
    chk("lh_strobe0", {mem_read, mem_write}, 2'b10);
    tick();
    chk("lh_addr1", mem_addr, 32'h21);
    chk("lh_noresp", resp_valid, 0);
    tick();
    chk("lh_resp_valid", resp_valid, 1);
    chk("lh_rdata_signed", resp_rdata, 32'hFFFF8001);
    tick();
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    tick();
    tick();
    chk("lhu_resp_valid", resp_valid, 1);
    chk("lhu_rdata", resp_rdata, 32'h00008001);
    tick();

    // Byte loads, including the top of the address space
    do_req(1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0);
    chk("lb_top_addr", mem_addr, 32'hFFFFFFFF);
    chk("lb_top_strobe", {mem_read, mem_write}, 2'b10);
    tick();
    chk("lb_top_resp", resp_valid, 1);
    chk("lb_top_rdata", resp_rdata, 32'h0000007F);
    chk("lb_top_read_drop", mem_read, 0);
    tick();
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    tick();
    chk("lb_neg_rdata", resp_rdata, 32'hFFFFFF80);
    tick();

    // Error requests: response one cycle after accept, no strobes
    begin
      int s0;
      s0 = strobe_cnt;
      do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
      chk("err_w_resp", {resp_valid, resp_err}, 2'b11);
      chk("err_w_rdata", resp_rdata, 0);
      chk("err_w_strobe", {mem_read, mem_write}, 0);
      tick();
      chk("err_w_drop", resp_valid, 0);
      chk("err_w_ready", req_ready, 1);
      do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFFFFFF);
      chk("err_sz_resp", {resp_valid, resp_err}, 2'b11);
      chk("err_sz_rdata", resp_rdata, 0);
      tick();
      do_req(1'b0, 2'b01, 1'b1, 32'h21, 32'h0);
      chk("err_h_resp", {resp_valid, resp_err}, 2'b11);
      tick();
      chk("err_no_strobes", strobe_cnt, s0);
    end

    // req_valid held through a word load: second accept exactly 6 cycles later
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b1;
    req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    tick();
    chk("hold_first_read", {mem_read, mem_addr}, {1'b1, 32'h10});
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("hold_ready_e%0d", k), req_ready, (k == 5) ? 1 : 0);
      if (k == 4) chk("hold_resp_rdata", {resp_valid, resp_rdata}, {1'b1, 32'hA1B2C3D4});
      if (k == 6) chk("hold_second_accept", {mem_read, mem_addr}, {1'b1, 32'h10});
    end
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("hold_idle", req_ready, 1);

    // Reset mid-cycle after the second byte of a word store
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    tick();
    tick();
    chk("rst_mid_writing", {mem_write, mem_addr}, {1'b1, 32'h12});
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_write_drop", mem_write, 0);
    chk("rst_mid_addr_zero", mem_addr, 0);
    chk("rst_mid_ready", req_ready, 1);
    tick();
    chk("rst_mid_noresp", resp_valid, 0);
    tick();
    chk("rst_mid_mem10", mem[6'h10], 8'h11);
    chk("rst_mid_mem11", mem[6'h11], 8'h22);
    chk("rst_mid_mem12", mem[6'h12], 8'hC3);
    chk("rst_mid_mem13", mem[6'h13], 8'hD4);
    reset = 1'b0;
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("post_rst_accept", {mem_read, mem_addr}, {1'b1, 32'h11});
    tick();
    chk("post_rst_rdata", {resp_valid, resp_rdata}, {1'b1, 32'h22});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
